// File: rtl/phoenix_memory_subsystem_if.sv
// Port bundle for phoenix_memory_subsystem: instruction port, data port and console sink.
// The slave modport is the memory side and the master modport is the requester side.
interface phoenix_memory_subsystem_if;
    logic        i_enable;
    logic [31:0] i_address;
    logic [31:0] i_data;
    logic        i_ready;

    logic        d_enable;
    logic        d_state;
    logic [31:0] d_address;
    logic [3:0]  d_frame_mask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;

    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready;

    modport slave (
        input  i_enable, i_address, d_enable, d_state, d_address, d_frame_mask, d_wdata,
               console_ready,
        output i_data, i_ready, d_rdata, d_ready, console_valid, console_data
    );

    modport master (
        output i_enable, i_address, d_enable, d_state, d_address, d_frame_mask, d_wdata,
               console_ready,
        input  i_data, i_ready, d_rdata, d_ready, console_valid, console_data
    );
endinterface

// File: rtl/phoenix_memory_subsystem.sv
// Dual-port (instruction/data) word memory with fixed access latency.
// Define PHOENIX_MEMORY_CONSOLE_EN to map CONSOLE_ADDR onto a byte FIFO console.
`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module phoenix_memory_subsystem #(
    parameter int          DEPTH_WORDS   = 65536,
    parameter int          LATENCY       = 1,
    parameter logic [31:0] CONSOLE_ADDR  = 32'h1000_0000,
    parameter int          CONSOLE_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    phoenix_memory_subsystem_if.slave        bus
);
    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} port_state_t;

    port_state_t i_state_reg, i_state_next;
    port_state_t d_state_reg, d_state_next;
    logic [3:0]  i_cnt_reg, i_cnt_next;
    logic [3:0]  d_cnt_reg, d_cnt_next;
    logic [29:0] i_word_reg, d_word_reg;
    logic        d_write_reg;
    logic [3:0]  d_mask_reg;
    logic [31:0] d_wdata_reg;

    logic        i_accept, d_accept, i_done, d_done, d_stall;
    logic        i_load, d_load;
    logic [29:0] i_rd_word, d_rd_word;
    logic        i_rd_hit, d_rd_hit, d_rd_con, d_cur_con, d_cur_hit, d_mem_we;
    logic [31:0] con_word, i_data_word, d_rdata_word;

    assign i_accept = (i_state_reg == IDLE) && bus.i_enable;
    assign d_accept = (d_state_reg == IDLE) && bus.d_enable;
    assign i_done   = (i_state_reg == BUSY) && (i_cnt_reg == 4'd0);
    assign d_done   = (d_state_reg == BUSY) && (d_cnt_reg == 4'd0);

    // Read data is captured on the edge that opens the ready cycle, so a write
    // committing at the end of that same cycle is not visible to it.
    assign i_load = (i_accept && (LAT_LOAD == 4'd0)) ||
                    ((i_state_reg == BUSY) && (i_cnt_reg == 4'd1));
    assign d_load = ((d_accept && (LAT_LOAD == 4'd0) && (bus.d_state != `WRITE)) ||
                     ((d_state_reg == BUSY) && (d_cnt_reg == 4'd1) && !d_write_reg));

    assign i_rd_word = (i_state_reg == IDLE) ? bus.i_address[31:2] : i_word_reg;
    assign d_rd_word = (d_state_reg == IDLE) ? bus.d_address[31:2] : d_word_reg;
    assign i_rd_hit  = {2'b00, i_rd_word}  < 32'(DEPTH_WORDS);
    assign d_rd_hit  = {2'b00, d_rd_word}  < 32'(DEPTH_WORDS);
    assign d_cur_hit = {2'b00, d_word_reg} < 32'(DEPTH_WORDS);

    assign d_mem_we     = d_done && !d_stall && d_write_reg && d_cur_hit && !d_cur_con;
    assign bus.i_ready  = i_done;
    assign bus.d_ready  = d_done && !d_stall;
    assign bus.i_data   = i_data_word;
    assign bus.d_rdata  = d_rdata_word;

`ifdef PHOENIX_MEMORY_CONSOLE_EN
    localparam int PW = (CONSOLE_DEPTH > 2) ? $clog2(CONSOLE_DEPTH) : 1;

    logic [7:0]  fifo_mem [CONSOLE_DEPTH];
    logic [PW:0] wr_ptr_reg, rd_ptr_reg;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop, con_req;
    logic        unused_bits;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                        (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign fifo_pop   = !fifo_empty && bus.console_ready;
    assign d_rd_con   = (d_rd_word  == CONSOLE_ADDR[31:2]);
    assign d_cur_con  = (d_word_reg == CONSOLE_ADDR[31:2]);
    assign con_req    = d_done && d_write_reg && d_cur_con && d_mask_reg[3];
    // A pop in the same cycle frees the slot the stalled push needs.
    assign d_stall    = con_req && fifo_full && !fifo_pop;
    assign fifo_push  = con_req && !d_stall;
    assign con_word   = {31'b0, fifo_full};

    assign bus.console_valid = !fifo_empty;
    assign bus.console_data  = fifo_empty ? 8'd0 : fifo_mem[rd_ptr_reg[PW-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg[PW-1:0]] <= d_wdata_reg[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    assign unused_bits = ^{bus.i_address[1:0], bus.d_address[1:0]};
`else
    logic unused_bits;

    assign d_stall           = 1'b0;
    assign d_rd_con          = 1'b0;
    assign d_cur_con         = 1'b0;
    assign con_word          = 32'd0;
    assign bus.console_valid = 1'b0;
    assign bus.console_data  = 8'd0;
    assign unused_bits       = ^{bus.i_address[1:0], bus.d_address[1:0], bus.console_ready};
`endif

    always_comb begin
        i_state_next = i_state_reg;
        i_cnt_next   = i_cnt_reg;
        case (i_state_reg)
            IDLE: if (bus.i_enable) begin
                i_state_next = BUSY;
                i_cnt_next   = LAT_LOAD;
            end
            BUSY: if (i_cnt_reg == 4'd0) i_state_next = IDLE;
                  else                   i_cnt_next   = i_cnt_reg - 4'd1;
            default: i_state_next = IDLE;
        endcase
    end

    always_comb begin
        d_state_next = d_state_reg;
        d_cnt_next   = d_cnt_reg;
        case (d_state_reg)
            IDLE: if (bus.d_enable) begin
                d_state_next = BUSY;
                d_cnt_next   = LAT_LOAD;
            end
            BUSY: if (d_cnt_reg == 4'd0) begin
                if (!d_stall) d_state_next = IDLE;
            end else begin
                d_cnt_next = d_cnt_reg - 4'd1;
            end
            default: d_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_state_reg <= IDLE;
            d_state_reg <= IDLE;
            i_cnt_reg   <= 4'd0;
            d_cnt_reg   <= 4'd0;
            i_word_reg  <= '0;
            d_word_reg  <= '0;
            d_write_reg <= 1'b0;
            d_mask_reg  <= 4'd0;
            d_wdata_reg <= 32'd0;
        end else begin
            i_state_reg <= i_state_next;
            d_state_reg <= d_state_next;
            i_cnt_reg   <= i_cnt_next;
            d_cnt_reg   <= d_cnt_next;
            if (i_accept) i_word_reg <= bus.i_address[31:2];
            if (d_accept) begin
                d_word_reg  <= bus.d_address[31:2];
                d_write_reg <= (bus.d_state == `WRITE);
                d_mask_reg  <= bus.d_frame_mask;
                d_wdata_reg <= bus.d_wdata;
            end
        end
    end

    // One RAM per byte lane; mask bit 3 selects the least significant byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] i_rd_reg, d_rd_reg;

            always_ff @(posedge clk) begin
                if (d_mem_we && d_mask_reg[3-gi]) begin
                    lane_mem[d_word_reg[AW-1:0]] <= d_wdata_reg[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    i_rd_reg <= 8'd0;
                    d_rd_reg <= 8'd0;
                end else begin
                    if (i_load) i_rd_reg <= i_rd_hit ? lane_mem[i_rd_word[AW-1:0]] : 8'd0;
                    if (d_load) d_rd_reg <= d_rd_con ? con_word[gi*8 +: 8] :
                                            d_rd_hit ? lane_mem[d_rd_word[AW-1:0]] : 8'd0;
                end
            end

            assign i_data_word[gi*8 +: 8]  = i_rd_reg;
            assign d_rdata_word[gi*8 +: 8] = d_rd_reg;
        end
    endgenerate
endmodule
